// File: rtl/bnn_param_loader.sv
// bnn_param_loader: serializes host parameter bytes, MSB first, into the
// daisy-chained binary-neuron parameter scan (setup / param_bit).
// Optional feature macro: BNN_LOADER_PARITY_EN adds a trailing parity check
// byte (CHECK state) and the cfg_err output.
//
// Handshake: a byte transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_data must be stable while cfg_valid is high.
// cfg_valid may stay high across bytes. cfg_ready is forced low while cfg_start
// is high, so a byte offered in a restart cycle is never taken.
module bnn_param_loader #(
  parameter int NEURONS   = 8,
  parameter int INPUTS    = 8,
  parameter int BIAS_BITS = 3,
  localparam int CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS),
  localparam int CNT_W      = $clog2(CHAIN_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [7:0]       cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             setup,
  output logic             param_bit,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_count
`ifdef BNN_LOADER_PARITY_EN
  ,
  output logic             cfg_err
`endif
);

`ifdef BNN_LOADER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    SHIFT     = 3'd2,
    DONE      = 3'd3,
    CHECK     = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_e;
`endif

  localparam logic [CNT_W-1:0] CHAIN_C = CNT_W'(CHAIN_BITS);

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             done_q, done_d;
  logic             setup_q, setup_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             hs;
  logic [31:0]      left_w;
  logic [3:0]       nbits;
  logic [CNT_W-1:0] cnt_inc;

`ifdef BNN_LOADER_PARITY_EN
  logic parity_q, parity_d;
  logic err_q, err_d;
  assign cfg_err = err_q;
`endif

  assign cfg_ready = ready_q & ~cfg_start;
  assign setup     = setup_q;
  assign param_bit = shreg_q[7];
  assign busy      = busy_q;
  assign done      = done_q;
  assign bit_count = bit_count_q;

  assign hs      = cfg_valid & cfg_ready;
  // Bits still owed to the chain; the final byte may only use its upper bits.
  assign left_w  = 32'(CHAIN_BITS) - 32'(bit_count_q);
  assign nbits   = (left_w >= 32'd8) ? 4'd8 : left_w[3:0];
  assign cnt_inc = (bit_count_q < CHAIN_C) ? bit_count_q + CNT_W'(1) : bit_count_q;

  // Next-state and datapath update; cfg_start overrides everything.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    rem_d       = rem_q;
    bit_count_d = bit_count_q;
    done_d      = done_q;
`ifdef BNN_LOADER_PARITY_EN
    parity_d    = parity_q;
    err_d       = err_q;
`endif
    if (cfg_start) begin
      state_d     = WAIT_BYTE;
      shreg_d     = '0;
      rem_d       = '0;
      bit_count_d = '0;
      done_d      = 1'b0;
`ifdef BNN_LOADER_PARITY_EN
      parity_d    = 1'b0;
      err_d       = 1'b0;
`endif
    end else begin
      case (state_q)
        WAIT_BYTE: begin
          if (hs) begin
            shreg_d = cfg_data;
            rem_d   = nbits;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          shreg_d     = {shreg_q[6:0], 1'b0};
          rem_d       = rem_q - 4'd1;
          bit_count_d = cnt_inc;
`ifdef BNN_LOADER_PARITY_EN
          parity_d    = parity_q ^ shreg_q[7];
`endif
          if (rem_q == 4'd1) begin
            if (cnt_inc == CHAIN_C) begin
`ifdef BNN_LOADER_PARITY_EN
              state_d = CHECK;
`else
              state_d = DONE;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = WAIT_BYTE;
            end
          end
        end
`ifdef BNN_LOADER_PARITY_EN
        CHECK: begin
          if (hs) begin
            err_d   = cfg_data[0] ^ parity_q;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
`endif
        default: begin
          // IDLE and DONE hold until cfg_start.
        end
      endcase
    end
  end

  // Registered output decode from the next state so outputs come straight off flops.
  always_comb begin
    setup_d = (state_d == SHIFT);
`ifdef BNN_LOADER_PARITY_EN
    busy_d  = (state_d == WAIT_BYTE) || (state_d == SHIFT) || (state_d == CHECK);
    ready_d = (state_d == WAIT_BYTE) || (state_d == CHECK);
`else
    busy_d  = (state_d == WAIT_BYTE) || (state_d == SHIFT);
    ready_d = (state_d == WAIT_BYTE);
`endif
  end

  // State and output registers; async reset drops setup immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      rem_q       <= '0;
      bit_count_q <= '0;
      done_q      <= 1'b0;
      setup_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      rem_q       <= rem_d;
      bit_count_q <= bit_count_d;
      done_q      <= done_d;
      setup_q     <= setup_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

`ifdef BNN_LOADER_PARITY_EN
  // Running parity of shifted bits and the latched check result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      parity_q <= parity_d;
      err_q    <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_bnn_param_loader.sv
// tb_bnn_param_loader: directed bench for bnn_param_loader.
// DUT a: default 88-bit chain. DUT b: NEURONS=3, BIAS_BITS=2 (30-bit chain).
// Inputs change #1 after posedge; outputs are sampled on negedge.
module tb_bnn_param_loader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] cfg_start, cfg_valid;
  logic [7:0] data_a, data_b;
  wire  [1:0] cfg_ready, setup, param_bit, busy, done;
  wire  [6:0] bc_a;
  wire  [4:0] bc_b;
`ifdef BNN_LOADER_PARITY_EN
  wire  [1:0] cfg_err;
`endif

  int checks;
  int errors;
  int pulses [2];
  logic [0:0] exp_q [$];
  logic exp_par;

  bnn_param_loader u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start[0]),
    .cfg_data  (data_a),
    .cfg_valid (cfg_valid[0]),
    .cfg_ready (cfg_ready[0]),
    .setup     (setup[0]),
    .param_bit (param_bit[0]),
    .busy      (busy[0]),
    .done      (done[0]),
`ifdef BNN_LOADER_PARITY_EN
    .cfg_err   (cfg_err[0]),
`endif
    .bit_count (bc_a)
  );

  bnn_param_loader #(.NEURONS(3), .INPUTS(8), .BIAS_BITS(2)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start[1]),
    .cfg_data  (data_b),
    .cfg_valid (cfg_valid[1]),
    .cfg_ready (cfg_ready[1]),
    .setup     (setup[1]),
    .param_bit (param_bit[1]),
    .busy      (busy[1]),
    .done      (done[1]),
`ifdef BNN_LOADER_PARITY_EN
    .cfg_err   (cfg_err[1]),
`endif
    .bit_count (bc_b)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bc(input int s);
    return (s == 1) ? 32'(bc_b) : 32'(bc_a);
  endfunction

  // Scoreboard: every setup cycle must carry the next expected bit.
  task automatic mon();
    logic [31:0] want;
    for (int s = 0; s < 2; s++) begin
      if (setup[s]) begin
        pulses[s]++;
        want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
        check_eq("param_bit", 32'(param_bit[s]), want);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic to_neg();
    @(negedge clk);
    mon();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    to_neg();
    to_pos();
  endtask

  task automatic set_data(input int s, input logic [7:0] d);
    if (s == 1) data_b = d;
    else        data_a = d;
  endtask

  task automatic push_byte(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[7-i]);
      exp_par = exp_par ^ d[7-i];
    end
  endtask

  task automatic start(input int s);
    cfg_start[s] = 1'b1;
    to_neg();
    check_eq("start_ready_low", 32'(cfg_ready[s]), 32'd0);
    to_pos();
    cfg_start[s] = 1'b0;
    to_neg();
    check_eq("start_ready", 32'(cfg_ready[s]), 32'd1);
    check_eq("start_busy", 32'(busy[s]), 32'd1);
    check_eq("start_done", 32'(done[s]), 32'd0);
    check_eq("start_count", bc(s), 32'd0);
    check_eq("start_setup", 32'(setup[s]), 32'd0);
    to_pos();
    exp_q.delete();
    exp_par = 1'b0;
  endtask

  task automatic send(input int s, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    set_data(s, d);
    cfg_valid[s] = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      to_neg();
      ok = cfg_ready[s];
      to_pos();
    end
    cfg_valid[s] = 1'b0;
    check_eq("handshake", 32'(ok), 32'd1);
  endtask

  // Returns at the negedge of the first non-shift cycle; cyc = shift cycles seen.
  task automatic drain(input int s, output int cyc);
    cyc = 0;
    to_neg();
    while (setup[s] && cyc < 40) begin
      cyc++;
      to_pos();
      to_neg();
    end
  endtask

  // Finishes a load; returns at the negedge of the first DONE cycle.
  task automatic close(input int s);
`ifdef BNN_LOADER_PARITY_EN
    check_eq("check_ready", 32'(cfg_ready[s]), 32'd1);
    check_eq("check_not_done", 32'(done[s]), 32'd0);
    to_pos();
    send(s, {7'd0, exp_par});
    to_neg();
    check_eq("parity_ok", 32'(cfg_err[s]), 32'd0);
`endif
    check_eq("load_done", 32'(done[s]), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int base;
    logic [7:0] d;
    checks = 0;
    errors = 0;
    pulses[0] = 0;
    pulses[1] = 0;
    exp_par = 1'b0;
    rst_n = 1'b0;
    cfg_start = '0;
    cfg_valid = '0;
    data_a = '0;
    data_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state of both instances.
    to_neg();
    for (int s = 0; s < 2; s++) begin
      check_eq("rst_ready", 32'(cfg_ready[s]), 32'd0);
      check_eq("rst_setup", 32'(setup[s]), 32'd0);
      check_eq("rst_param", 32'(param_bit[s]), 32'd0);
      check_eq("rst_busy", 32'(busy[s]), 32'd0);
      check_eq("rst_done", 32'(done[s]), 32'd0);
      check_eq("rst_count", bc(s), 32'd0);
    end
    to_pos();

    // Full 88-bit load of 0xA5 with cfg_valid held.
    start(0);
    base = pulses[0];
    for (int i = 0; i < 11; i++) begin
      push_byte(8'hA5, 8);
      send(0, 8'hA5);
    end
    drain(0, cyc);
    check_eq("a5_last_shifts", 32'(cyc), 32'd8);
    close(0);
    check_eq("a5_pulses", 32'(pulses[0] - base), 32'd88);
    check_eq("a5_count", bc(0), 32'd88);
    check_eq("a5_busy", 32'(busy[0]), 32'd0);
    check_eq("a5_ready", 32'(cfg_ready[0]), 32'd0);
    check_eq("a5_queue_empty", 32'(exp_q.size()), 32'd0);
    to_pos();

    // DONE holds and ignores cfg_valid.
    cfg_valid[0] = 1'b1;
    data_a = 8'hFF;
    to_neg();
    check_eq("done_ready_low", 32'(cfg_ready[0]), 32'd0);
    to_pos();
    to_neg();
    check_eq("done_no_setup", 32'(setup[0]), 32'd0);
    check_eq("done_held", 32'(done[0]), 32'd1);
    check_eq("done_count_sat", bc(0), 32'd88);
    to_pos();
    cfg_valid[0] = 1'b0;

    // 30-bit chain: last byte 0xFC contributes only its upper 6 bits.
    start(1);
    base = pulses[1];
    push_byte(8'h3C, 8);
    send(1, 8'h3C);
    push_byte(8'h81, 8);
    send(1, 8'h81);
    push_byte(8'h5A, 8);
    send(1, 8'h5A);
    push_byte(8'hFC, 6);
    send(1, 8'hFC);
    drain(1, cyc);
    check_eq("b_partial_shifts", 32'(cyc), 32'd6);
    close(1);
    check_eq("b_pulses", 32'(pulses[1] - base), 32'd30);
    check_eq("b_count", bc(1), 32'd30);
    check_eq("b_busy", 32'(busy[1]), 32'd0);
    check_eq("b_queue_empty", 32'(exp_q.size()), 32'd0);
    to_pos();

    // Restart during the 5th shift of the 3rd byte.
    start(0);
    push_byte(8'h11, 8);
    send(0, 8'h11);
    push_byte(8'h22, 8);
    send(0, 8'h22);
    push_byte(8'h33, 8);
    send(0, 8'h33);
    repeat (4) tick();
    cfg_start[0] = 1'b1;
    to_neg();
    check_eq("abort_shifting", 32'(setup[0]), 32'd1);
    check_eq("abort_ready_low", 32'(cfg_ready[0]), 32'd0);
    to_pos();
    cfg_start[0] = 1'b0;
    to_neg();
    check_eq("abort_setup", 32'(setup[0]), 32'd0);
    check_eq("abort_count", bc(0), 32'd0);
    check_eq("abort_done", 32'(done[0]), 32'd0);
    check_eq("abort_ready", 32'(cfg_ready[0]), 32'd1);
    to_pos();
    exp_q.delete();
    exp_par = 1'b0;
    base = pulses[0];
    for (int i = 0; i < 11; i++) begin
      d = 8'(i * 37 + 5);
      push_byte(d, 8);
      send(0, d);
    end
    drain(0, cyc);
    check_eq("reload_last_shifts", 32'(cyc), 32'd8);
    close(0);
    check_eq("reload_pulses", 32'(pulses[0] - base), 32'd88);
    check_eq("reload_count", bc(0), 32'd88);
    to_pos();

    // cfg_start and cfg_valid together: byte refused, taken next cycle.
    start(0);
    cfg_start[0] = 1'b1;
    cfg_valid[0] = 1'b1;
    data_a = 8'hFF;
    to_neg();
    check_eq("startvalid_ready_low", 32'(cfg_ready[0]), 32'd0);
    to_pos();
    cfg_start[0] = 1'b0;
    to_neg();
    check_eq("startvalid_not_taken", 32'(setup[0]), 32'd0);
    check_eq("startvalid_ready", 32'(cfg_ready[0]), 32'd1);
    push_byte(8'hFF, 8);
    to_pos();
    cfg_valid[0] = 1'b0;
    drain(0, cyc);
    check_eq("ff_shifts", 32'(cyc), 32'd8);
    check_eq("ff_count", bc(0), 32'd8);
    check_eq("ff_wait_ready", 32'(cfg_ready[0]), 32'd1);
    check_eq("ff_busy", 32'(busy[0]), 32'd1);
    check_eq("ff_done", 32'(done[0]), 32'd0);
    to_pos();

    // Asynchronous reset in the middle of a shift.
    push_byte(8'h0F, 8);
    send(0, 8'h0F);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_setup", 32'(setup[0]), 32'd0);
    check_eq("arst_busy", 32'(busy[0]), 32'd0);
    check_eq("arst_ready", 32'(cfg_ready[0]), 32'd0);
    check_eq("arst_count", bc(0), 32'd0);
    exp_q.delete();
    to_pos();
    rst_n = 1'b1;
    cfg_valid[0] = 1'b1;
    data_a = 8'hAA;
    to_neg();
    check_eq("idle_done", 32'(done[0]), 32'd0);
    check_eq("idle_ready", 32'(cfg_ready[0]), 32'd0);
    check_eq("idle_busy", 32'(busy[0]), 32'd0);
    to_pos();
    to_neg();
    check_eq("idle_ignores_valid", 32'(setup[0]), 32'd0);
    to_pos();
    cfg_valid[0] = 1'b0;

`ifdef BNN_LOADER_PARITY_EN
    // Parity check byte: 11 x 0x01 has odd parity.
    start(0);
    for (int i = 0; i < 11; i++) begin
      push_byte(8'h01, 8);
      send(0, 8'h01);
    end
    drain(0, cyc);
    check_eq("par_check_ready", 32'(cfg_ready[0]), 32'd1);
    check_eq("par_check_busy", 32'(busy[0]), 32'd1);
    check_eq("par_check_done", 32'(done[0]), 32'd0);
    to_pos();
    send(0, 8'h00);
    to_neg();
    check_eq("par_bad_err", 32'(cfg_err[0]), 32'd1);
    check_eq("par_bad_done", 32'(done[0]), 32'd1);
    to_pos();
    start(0);
    check_eq("par_err_cleared", 32'(cfg_err[0]), 32'd0);
    for (int i = 0; i < 11; i++) begin
      push_byte(8'h01, 8);
      send(0, 8'h01);
    end
    drain(0, cyc);
    to_pos();
    send(0, 8'h01);
    to_neg();
    check_eq("par_good_err", 32'(cfg_err[0]), 32'd0);
    check_eq("par_good_done", 32'(done[0]), 32'd1);
    to_pos();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_param_loader.md
Name: bnn_param_loader

Overview:
- Configuration sequencer for the binary-neuron array.
- Accepts parameter bytes from the host over a valid/ready byte interface and serializes them, one bit per cycle, into the daisy-chained neuron parameter scan (setup / param_in).
- Counts exactly NEURONS*(INPUTS+BIAS_BITS) shifts, then drops setup and flags done so inference logic can use the array.

Parameters:
- NEURONS, 8, number of neurons in the scan chain.
- INPUTS, 8, weight bits per neuron.
- BIAS_BITS, 3, bias bits per neuron.
- Derived (localparam): CHAIN_BITS = NEURONS*(INPUTS+BIAS_BITS); CNT_W = $clog2(CHAIN_BITS+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  one-cycle pulse: begin (or restart) a load.
- cfg_data  in  8  parameter byte, serialized MSB first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  loader can accept a byte.
- setup  out  1  to neuron setup; high only on cycles that shift one bit.
- param_bit  out  1  to param_in of the first neuron in the chain.
- busy  out  1  load in progress.
- done  out  1  all CHAIN_BITS shifted; held until next cfg_start.
- bit_count  out  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset (async, rst_n=0): state IDLE. cfg_ready, setup, param_bit, busy and done are 0. bit_count=0. Shift register cleared.
- All outputs are registered.
- States:
  - IDLE: done is held at its last value.
  - WAIT_BYTE: cfg_ready=1, busy=1.
  - SHIFT: cfg_ready=0, busy=1, setup=1.
  - DONE: done=1, busy=0.
- cfg_start in any state:
  - Next state WAIT_BYTE. bit_count cleared, done cleared.
  - An in-flight byte is discarded and setup is low the following cycle.
  - cfg_start has priority: a cfg_valid in the same cycle is not accepted. cfg_ready is driven low combinationally during cfg_start.
- WAIT_BYTE: on cfg_valid & cfg_ready, latch cfg_data and compute nbits = min(8, CHAIN_BITS-bit_count); go to SHIFT.
- SHIFT: each cycle shifts one bit.
  - setup=1 and param_bit=latched[7], then latched <<= 1; bit_count+1.
  - After nbits cycles: if bit_count==CHAIN_BITS go to DONE, else go to WAIT_BYTE.
  - A byte handshake can complete no sooner than 1 cycle after the last shift of the previous byte. Peak throughput is 8 bits per 9 cycles.
- Last partial byte: only its upper CHAIN_BITS mod 8 bits are used; the remaining low bits are ignored.
- Bit ordering: the first bit shifted ends in the bias MSB of the last neuron in the chain. The host supplies the stream last-neuron-first, bias MSB first, then weights MSB first.
- setup is never asserted outside SHIFT. Neuron contents are frozen in IDLE, WAIT_BYTE and DONE.
- cfg_valid without an open load (IDLE or DONE) is ignored; cfg_ready=0 there.
- Reset mid-SHIFT: setup drops immediately (async). The chain holds partial data; done=0 flags the array as unconfigured.
- bit_count saturates at CHAIN_BITS and never wraps.

Optional Feature:
- Macro: BNN_LOADER_PARITY_EN.
- Defined:
  - After the last data byte, the loader enters CHECK (cfg_ready=1, setup=0) and accepts one extra byte. Its bit 0 is the expected even parity (XOR) of all CHAIN_BITS shifted bits.
  - Added output cfg_err (1 bit, reset 0): set on mismatch, cleared by cfg_start.
  - done rises only after the check byte is accepted, whether or not cfg_err is set.
- Not defined: no CHECK state, no cfg_err port; DONE is entered directly after the last shift.

Test Plan:
- Default params (88 bits): 11 bytes of 0xA5 with cfg_valid held high -> setup pulses total 88, param_bit sequence 1,0,1,0,0,1,0,1 repeated, done=1 one cycle after the 88th shift, bit_count=88.
- NEURONS=3, INPUTS=8, BIAS_BITS=2 (30 bits): 4 bytes, last byte 0xFC -> last byte yields exactly 6 shifts of 1, done after 30 shifts, low 2 bits ignored.
- cfg_start pulsed during the 5th shift of the 3rd byte -> setup low next cycle, bit_count=0, done=0, cfg_ready=1; a fresh full load then completes normally with done=1.
- cfg_start and cfg_valid in the same cycle, data 0xFF -> byte not accepted (cfg_ready=0 that cycle); the next cycle with cfg_valid is accepted.
- rst_n asserted asynchronously mid-SHIFT (between clock edges) -> setup, busy, cfg_ready go 0 immediately; after release, state is IDLE with done=0.
- With BNN_LOADER_PARITY_EN: 11 bytes of 0x01 (parity 1) followed by a check byte of 0x00 -> cfg_err=1, done=1. Repeat with check byte 0x01 -> cfg_err=0, done=1.
